shift_frame_controller: RTL

- Sequences a WIDTH-bit serial shift path: accepts a parallel word on a valid/ready handshake, shifts it out on sdo one bit per clock, and shifts sdi in on the same edges.
- Presents the captured word on a valid/ready output.
- Sits between a parallel producer/consumer and the serial shift chain, and owns all framing, bit counting and backpressure for that chain.

---
 rtl/shift_ctrl_pkg.sv | 15 +
 rtl/shift_reg_pl.sv | 45 ++++
 rtl/shift_frame_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the serial shift frame controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_pl.sv
// WIDTH-bit shift register with parallel load, shift enable and
// selectable direction. MSB_FIRST shifts toward the MSB (serial out on
// the MSB, serial in on the LSB); otherwise the mirror image.
module shift_reg_pl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_pnext
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Value the register takes on a shift, including the incoming serial bit.
  always_comb begin
    w_next = r_q;
    if (MSB_FIRST) begin
      w_next = {r_q[WIDTH-2:0], i_sin};
    end else begin
      w_next = {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_sout  = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
  assign o_pnext = w_next;

  // Parallel load has priority over shifting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pdata;
    end else if (i_shift) begin
      r_q <= w_next;
    end
  end

endmodule

// File: rtl/shift_frame_controller.sv
// Serial shift frame controller: accepts a parallel word, shifts it out on
// sdo while capturing sdi, and presents the captured word on a valid/ready
// output with backpressure, optional inter-frame gap and frame abort.
module shift_frame_controller
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             sdo,
  output logic             sdo_active,
  input  logic             sdi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_done
);

  localparam int unsigned    CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_in_shift;
  logic             w_rx_shift;
  logic             w_last_bit;
  logic             w_tx_sout;
  logic [WIDTH-1:0] w_rx_next;
  logic [WIDTH-1:0] w_tx_pnext_unused;
  logic             w_rx_sout_unused;

  assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_in_shift = (r_state == SHIFT);
  // An aborted cycle neither samples sdi nor completes the frame.
  assign w_rx_shift = w_in_shift && !abort;
  assign w_last_bit = w_rx_shift && (r_bit_cnt == LAST_BIT);

  assign sdo        = w_in_shift & w_tx_sout;
  assign sdo_active = w_in_shift;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

  shift_reg_pl #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx_sr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_accept),
    .i_pdata (in_data),
    .i_shift (w_in_shift),
    .i_sin   (1'b0),
    .o_sout  (w_tx_sout),
    .o_pnext (w_tx_pnext_unused)
  );

  // Cleared on every load so an aborted frame leaves nothing behind.
  shift_reg_pl #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_rx_sr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_accept),
    .i_pdata ('0),
    .i_shift (w_rx_shift),
    .i_sin   (sdi),
    .o_sout  (w_rx_sout_unused),
    .o_pnext (w_rx_next)
  );

  // Frame sequencing: IDLE -> SHIFT (WIDTH bits) -> optional GAP -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (r_bit_cnt == LAST_BIT) begin
            r_state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output word register: the last received bit is folded in directly from
  // the rx next-value so the word appears one cycle after the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_bit;
      if (w_last_bit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rx_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
